// File: rtl/char_term_writer.sv
// Terminal-style front end for the character RAM write port: consumes an ASCII
// byte stream, tracks a cursor, handles CR/LF/BS/FF, and clears rows as they are entered.
module char_term_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] write_character_pos,
  output logic [7:0]        write_character,
  output logic              write_strobe,
  output logic [ADDR_W-1:0] cursor_pos
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(COLS - 1);
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {CLR_ALL, IDLE, WRAP, CLR_ROW} state_t;

  state_t            state;
  logic [ADDR_W-1:0] row_base;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] clr_addr;
  logic [COL_W-1:0]  clr_col;
  // A byte accepted on one edge is written on the next; this stage holds it.
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;

  logic [ADDR_W-1:0] next_row_base;
  logic              accept;
  logic              printable;

  assign next_row_base = (row_base == LAST_ROW_BASE) ? '0 : row_base + ROW_STEP;
  assign accept        = in_valid & in_ready;
  assign printable     = (in_byte >= 8'h20) && (in_byte <= 8'h7E);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state               <= CLR_ALL;
      row_base            <= '0;
      col                 <= '0;
      cursor_pos          <= '0;
      clr_addr            <= '0;
      clr_col             <= '0;
      pend_valid          <= 1'b0;
      pend_addr           <= '0;
      pend_data           <= CH_SPACE;
      in_ready            <= 1'b0;
      write_strobe        <= 1'b0;
      write_character_pos <= '0;
      write_character     <= CH_SPACE;
    end else begin
      write_strobe <= 1'b0;
      case (state)
        CLR_ALL: begin
          write_strobe        <= 1'b1;
          write_character_pos <= clr_addr;
          write_character     <= CH_SPACE;
          if (clr_addr == LAST_ADDR) state <= IDLE;
          else                       clr_addr <= clr_addr + 1'b1;
        end

        WRAP: begin
          // The character that filled the last column goes out here.
          write_strobe        <= pend_valid;
          write_character_pos <= pend_addr;
          write_character     <= pend_data;
          pend_valid          <= 1'b0;
          state               <= CLR_ROW;
        end

        CLR_ROW: begin
          write_strobe        <= 1'b1;
          write_character_pos <= clr_addr;
          write_character     <= CH_SPACE;
          if (clr_col == LAST_COL) begin
            state <= IDLE;
          end else begin
            clr_col  <= clr_col + 1'b1;
            clr_addr <= clr_addr + 1'b1;
          end
        end

        IDLE: begin
          in_ready     <= 1'b1;
          write_strobe <= pend_valid;
          if (pend_valid) begin
            write_character_pos <= pend_addr;
            write_character     <= pend_data;
          end
          pend_valid <= 1'b0;
          if (accept) begin
            if (printable) begin
              pend_valid <= 1'b1;
              pend_addr  <= cursor_pos;
              pend_data  <= in_byte;
              if (col == LAST_COL) begin
                col        <= '0;
                row_base   <= next_row_base;
                cursor_pos <= next_row_base;
                clr_addr   <= next_row_base;
                clr_col    <= '0;
                state      <= WRAP;
                in_ready   <= 1'b0;
              end else begin
                col        <= col + 1'b1;
                cursor_pos <= cursor_pos + 1'b1;
              end
            end else begin
              case (in_byte)
                CH_LF: begin
                  col        <= '0;
                  row_base   <= next_row_base;
                  cursor_pos <= next_row_base;
                  clr_addr   <= next_row_base;
                  clr_col    <= '0;
                  state      <= CLR_ROW;
                  in_ready   <= 1'b0;
                end
                CH_CR: begin
                  col        <= '0;
                  cursor_pos <= row_base;
                end
                CH_BS: begin
                  if (col != '0) begin
                    col        <= col - 1'b1;
                    cursor_pos <= cursor_pos - 1'b1;
                    pend_valid <= 1'b1;
                    pend_addr  <= cursor_pos - 1'b1;
                    pend_data  <= CH_SPACE;
                  end
                end
                CH_FF: begin
                  col        <= '0;
                  row_base   <= '0;
                  cursor_pos <= '0;
                  clr_addr   <= '0;
                  state      <= CLR_ALL;
                  in_ready   <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end

        default: state <= CLR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_char_term_writer.sv
// Bench for char_term_writer: directed vector table, multi-cycle corner sequences,
// and random byte streams compared against a screen/cursor model.
module tb_char_term_writer;
  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int ADDR_W = 11;
  localparam int CELLS  = COLS * ROWS;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] write_character_pos;
  logic [7:0]        write_character;
  logic              write_strobe;
  logic [ADDR_W-1:0] cursor_pos;

  char_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .in_byte             (in_byte),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .write_character_pos (write_character_pos),
    .write_character     (write_character),
    .write_strobe        (write_strobe),
    .cursor_pos          (cursor_pos)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_addr = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  logic [7:0] shadow [0:2047];

  always @(posedge CLK) cyc <= cyc + 1;

  // Write monitor: logs every strobe and mirrors it into a shadow screen.
  always @(negedge CLK) begin
    if (write_strobe === 1'b1) begin
      wr_addr_q.push_back(int'(write_character_pos));
      wr_data_q.push_back(int'(write_character));
      wr_cyc_q.push_back(cyc);
      if (int'(write_character_pos) >= CELLS) bad_addr++;
      shadow[write_character_pos] = write_character;
    end
  end

  // Reference model: screen as an array, cursor as row/col.
  logic [7:0] model_mem [0:CELLS-1];
  int m_row = 0;
  int m_col = 0;

  function automatic void model_clear_all();
    for (int i = 0; i < CELLS; i++) model_mem[i] = 8'h20;
  endfunction

  function automatic void model_next_row();
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) model_mem[m_row * COLS + c] = 8'h20;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_mem[m_row * COLS + m_col] = b;
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_next_row();
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_next_row();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        model_mem[m_row * COLS + m_col] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      model_clear_all();
    end
  endfunction

  function automatic int model_cursor();
    return m_row * COLS + m_col;
  endfunction

  function automatic int mem_mismatches();
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (shadow[i] !== model_mem[i]) n++;
    return n;
  endfunction

  function automatic int log_addr(input int i);
    if (i < 0 || i >= wr_addr_q.size()) return -1;
    return wr_addr_q[i];
  endfunction

  function automatic int log_data(input int i);
    if (i < 0 || i >= wr_data_q.size()) return -1;
    return wr_data_q[i];
  endfunction

  // Counts entries of a run that are not spaces at consecutive addresses on consecutive cycles.
  function automatic int clear_run_errors(input int first, input int n, input int start_addr, input int start_cyc);
    int bad = 0;
    if (wr_addr_q.size() < first + n) return n;
    for (int i = 0; i < n; i++)
      if (wr_addr_q[first+i] != start_addr + i || wr_data_q[first+i] != 32'h20 ||
          wr_cyc_q[first+i] != start_cyc + i) bad++;
    return bad;
  endfunction

  function automatic logic [7:0] rand_byte();
    int r = int'($urandom_range(0, 99));
    if (r < 68) return 8'($urandom_range(32, 126));
    if (r < 76) return 8'h0D;
    if (r < 84) return 8'h0A;
    if (r < 93) return 8'h08;
    if (r < 99) return ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(127, 255));
    return 8'h0C;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (in_ready !== 1'b1 && lat < 5000);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (in_ready !== 1'b1 && g < 5000) begin
      tick();
      g++;
    end
  endtask

  // Sends one byte, then runs until in_ready returns; the log holds only this byte's writes.
  task automatic send_wait(input logic [7:0] b, output int acc, output int lat, output int nwr);
    wait_idle();
    clear_log();
    in_byte  = b;
    in_valid = 1'b1;
    tick();
    acc      = cyc;
    in_valid = 1'b0;
    model_byte(b);
    wait_ready(lat);
    nwr = wr_addr_q.size();
  endtask

  // Streams bytes with optional idle gaps; each byte is held until accepted.
  task automatic drive_stream(input logic [7:0] s[$], input int gap_pct, output int sent);
    int budget = 0;
    bit acc_now;
    sent = 0;
    while (sent < s.size() && budget < 40000) begin
      if (!in_valid && int'($urandom_range(0, 99)) >= gap_pct) begin
        in_valid = 1'b1;
        in_byte  = s[sent];
      end
      acc_now = in_valid && (in_ready === 1'b1);
      tick();
      budget++;
      if (acc_now) begin
        model_byte(s[sent]);
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [7:0] b;
    int         cursor;
    int         lat;
    int         nwr;
    int         last_addr;
    int         last_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [7:0] b, input int cur, input int lat,
                                  input int nwr, input int la, input int ld);
    vec_t v;
    v.b = b; v.cursor = cur; v.lat = lat; v.nwr = nwr; v.last_addr = la; v.last_data = ld;
    vecs.push_back(v);
  endfunction

  initial begin
    repeat (150000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, lat, nwr, rel, g, sent, got_off;
    logic [7:0] s[$];

    // Table starts from cursor 2 (after the back-to-back "Hi" sequence).
    add_vec(8'h0D,    0,    1,    0,   -1,   -1);
    add_vec(8'h48,    1,    1,    1,    0, 8'h48);
    add_vec(8'h69,    2,    1,    1,    1, 8'h69);
    add_vec(8'h08,    1,    1,    1,    1, 8'h20);
    add_vec(8'h0D,    0,    1,    0,   -1,   -1);
    add_vec(8'h08,    0,    1,    0,   -1,   -1);
    add_vec(8'h01,    0,    1,    0,   -1,   -1);
    add_vec(8'h7E,    1,    1,    1,    0, 8'h7E);
    add_vec(8'h0A,   80,   81,   80,  159, 8'h20);
    add_vec(8'h7F,   80,    1,    0,   -1,   -1);
    add_vec(8'h20,   81,    1,    1,   80, 8'h20);
    add_vec(8'h0D,   80,    1,    0,   -1,   -1);
    add_vec(8'h0C,    0, 2001, 2000, 1999, 8'h20);
    add_vec(8'h5A,    1,    1,    1,    0, 8'h5A);
    add_vec(8'h62,    2,    1,    1,    1, 8'h62);
    add_vec(8'h63,    3,    1,    1,    2, 8'h63);
    add_vec(8'h08,    2,    1,    1,    2, 8'h20);
    add_vec(8'h0D,    0,    1,    0,   -1,   -1);
    add_vec(8'h08,    0,    1,    0,   -1,   -1);

    // Reset and power-up clear.
    RST = 1'b1;
    repeat (3) tick();
    chk("reset_strobe", int'(write_strobe), 0);
    chk("reset_ready", int'(in_ready), 0);
    chk("reset_cursor", int'(cursor_pos), 0);
    clear_log();
    RST = 1'b0;
    rel = cyc;
    wait_ready(lat);
    chk("init_ready_latency", lat, CELLS + 1);
    chk("init_write_count", wr_addr_q.size(), CELLS);
    chk("init_write_run", clear_run_errors(0, CELLS, 0, rel + 1), 0);
    model_clear_all();
    m_row = 0;
    m_col = 0;
    $display("init: writes=%0d ready_latency=%0d", wr_addr_q.size(), lat);

    // Back-to-back 'H','i'.
    clear_log();
    in_byte  = 8'h48;
    in_valid = 1'b1;
    tick();
    acc = cyc;
    model_byte(8'h48);
    chk("b2b_ready_held", int'(in_ready), 1);
    in_byte = 8'h69;
    tick();
    model_byte(8'h69);
    in_valid = 1'b0;
    tick();
    chk("b2b_count", wr_addr_q.size(), 2);
    chk("b2b_addr0", log_addr(0), 0);
    chk("b2b_data0", log_data(0), 8'h48);
    chk("b2b_addr1", log_addr(1), 1);
    chk("b2b_data1", log_data(1), 8'h69);
    chk("b2b_first_cycle", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - acc : -1, 1);
    chk("b2b_consecutive", (wr_cyc_q.size() > 1) ? wr_cyc_q[1] - wr_cyc_q[0] : -1, 1);
    chk("b2b_cursor", int'(cursor_pos), 2);
    $display("b2b: writes=%0d cursor=%0d", wr_addr_q.size(), cursor_pos);

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      send_wait(vecs[i].b, acc, lat, nwr);
      got_off = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - acc : -1;
      chk($sformatf("vec%0d_cursor", i), int'(cursor_pos), vecs[i].cursor);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_writes", i), nwr, vecs[i].nwr);
      chk($sformatf("vec%0d_last_addr", i), log_addr(nwr - 1), vecs[i].last_addr);
      chk($sformatf("vec%0d_last_data", i), log_data(nwr - 1), vecs[i].last_data);
      chk($sformatf("vec%0d_first_cycle", i), got_off, (vecs[i].nwr > 0) ? 1 : -1);
      $display("vec %0d: byte=0x%02h cursor=%0d latency=%0d writes=%0d", i, vecs[i].b, cursor_pos, lat, nwr);
    end

    // End-of-line wrap from column 79.
    send_wait(8'h0D, acc, lat, nwr);
    s.delete();
    for (int i = 0; i < 79; i++) s.push_back(8'(8'h61 + i % 26));
    drive_stream(s, 0, sent);
    chk("wrap_pre_cursor", int'(cursor_pos), 79);
    send_wait(8'h41, acc, lat, nwr);
    chk("wrap_latency", lat, COLS + 2);
    chk("wrap_writes", nwr, COLS + 1);
    chk("wrap_char_addr", log_addr(0), 79);
    chk("wrap_char_data", log_data(0), 8'h41);
    chk("wrap_char_cycle", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - acc : -1, 1);
    chk("wrap_clear_run", clear_run_errors(1, COLS, 80, acc + 2), 0);
    chk("wrap_cursor", int'(cursor_pos), 80);
    $display("wrap: writes=%0d latency=%0d cursor=%0d", nwr, lat, cursor_pos);

    // LF on the last row wraps to row 0; then CR.
    s.delete();
    for (int i = 0; i < 23; i++) s.push_back(8'h0A);
    for (int i = 0; i < 5; i++) s.push_back(8'(8'h30 + i));
    drive_stream(s, 0, sent);
    chk("lastrow_cursor", int'(cursor_pos), 24 * COLS + 5);
    send_wait(8'h0A, acc, lat, nwr);
    chk("lastrow_lf_latency", lat, COLS + 1);
    chk("lastrow_lf_writes", nwr, COLS);
    chk("lastrow_lf_run", clear_run_errors(0, COLS, 0, acc + 1), 0);
    chk("lastrow_lf_cursor", int'(cursor_pos), 0);
    s.delete();
    for (int i = 0; i < 7; i++) s.push_back(8'(8'h41 + i));
    drive_stream(s, 0, sent);
    chk("cr_pre_cursor", int'(cursor_pos), 7);
    send_wait(8'h0D, acc, lat, nwr);
    chk("cr_writes", nwr, 0);
    chk("cr_cursor", int'(cursor_pos), 0);
    $display("lastrow: lf_writes=%0d cursor_after_cr=%0d", COLS, cursor_pos);

    // FF mid-line, then reset during its clear at address 500.
    s.delete();
    s.push_back(8'h78);
    s.push_back(8'h79);
    drive_stream(s, 0, sent);
    wait_idle();
    clear_log();
    in_byte  = 8'h0C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_byte(8'h0C);
    g = 0;
    while ((wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size()-1] != 500) && g < 3000) begin
      tick();
      g++;
    end
    chk("ff_reached_500", log_addr(wr_addr_q.size() - 1), 500);
    RST = 1'b1;
    tick();
    chk("midreset_strobe", int'(write_strobe), 0);
    chk("midreset_ready", int'(in_ready), 0);
    chk("midreset_cursor", int'(cursor_pos), 0);
    clear_log();
    RST = 1'b0;
    rel = cyc;
    wait_ready(lat);
    chk("midreset_latency", lat, CELLS + 1);
    chk("midreset_writes", wr_addr_q.size(), CELLS);
    chk("midreset_run", clear_run_errors(0, CELLS, 0, rel + 1), 0);
    m_row = 0;
    m_col = 0;
    model_clear_all();
    chk("midreset_screen", mem_mismatches(), 0);
    $display("midreset: writes=%0d latency=%0d", wr_addr_q.size(), lat);

    // Random streams against the model.
    for (int r = 0; r < 4; r++) begin
      s.delete();
      for (int i = 0; i < 150; i++) s.push_back(rand_byte());
      drive_stream(s, (r % 2 == 1) ? 30 : 0, sent);
      wait_idle();
      tick();
      chk($sformatf("rand%0d_sent", r), sent, 150);
      chk($sformatf("rand%0d_cursor", r), int'(cursor_pos), model_cursor());
      chk($sformatf("rand%0d_screen", r), mem_mismatches(), 0);
      $display("random round %0d: bytes=%0d cursor=%0d model_cursor=%0d", r, sent, cursor_pos, model_cursor());
    end

    chk("addr_in_range", bad_addr, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
